// File: rtl/apb_reg_bridge.sv
// APB slave front end for the timer register bank: converts APB transfers into single-cycle
// bank strobes, inserts wait states, merges byte strobes by read-modify-write, flags bad addresses.
module apb_reg_bridge #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned MAX_ADDR    = 'h1C
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr,
    output logic [ADDR_W-1:0]   reg_addr,
    output logic [DATA_W-1:0]   reg_wr_data,
    output logic                reg_wr_en,
    output logic                reg_rd_en,
    input  logic [DATA_W-1:0]   reg_rd_data
);

    localparam int unsigned          STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0]    MAX_A  = ADDR_W'(MAX_ADDR);
    localparam logic [3:0]           WAIT_N = 4'(WAIT_STATES);
    localparam logic [STRB_W-1:0]    STRB_ALL = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                write_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   merged;
    logic                setup;

    assign setup = (state == ST_IDLE) && psel && !penable;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (setup) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!psel)                  state_nxt = ST_IDLE;
                else if (cnt == 4'd0) begin
                    if (err_q)              state_nxt = ST_RESP;
                    else if (!write_q)      state_nxt = ST_READ;
                    else if (strb_q == STRB_ALL) state_nxt = ST_WRITE;
                    else if (strb_q == '0)  state_nxt = ST_RESP;
                    else                    state_nxt = ST_RMW_RD;
                end
            end
            ST_READ:   state_nxt = psel ? ST_RESP  : ST_IDLE;
            ST_RMW_RD: state_nxt = psel ? ST_WRITE : ST_IDLE;
            ST_WRITE:  state_nxt = psel ? ST_RESP  : ST_IDLE;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        merged = reg_rd_data;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb_q[b]) merged[b*8 +: 8] = wdata_q[b*8 +: 8];
        end
    end

    // Strobes are gated by psel so an aborted transfer issues nothing in its abort cycle.
    always_comb begin
        pready    = (state == ST_RESP);
        pslverr   = (state == ST_RESP) && err_q;
        prdata    = (state == ST_RESP) ? rdata_q : '0;
        reg_rd_en = psel && ((state == ST_READ) || (state == ST_RMW_RD));
        reg_wr_en = psel && (state == ST_WRITE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            reg_addr    <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            reg_wr_data <= '0;
        end else begin
            state <= state_nxt;
            if (setup) begin
                reg_addr <= paddr;
                wdata_q  <= pwdata;
                strb_q   <= pstrb;
                write_q  <= pwrite;
                err_q    <= (paddr[1:0] != 2'b00) || (paddr > MAX_A);
                cnt      <= WAIT_N;
                rdata_q  <= '0;
            end
            if (state == ST_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state == ST_WAIT && state_nxt == ST_WRITE) reg_wr_data <= wdata_q;
            if (state == ST_READ && psel) rdata_q <= reg_rd_data;
            if (state == ST_RMW_RD && psel) reg_wr_data <= merged;
        end
    end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Bench for apb_reg_bridge: two instances (0 and 3 wait states) each with a behavioural bank,
// a vector table for the documented cases, hand sequences for abort/reset, and random transfers.
module tb_apb_reg_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel_v    [2];
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready_v  [2];
    logic [31:0] prdata_v  [2];
    logic        pslverr_v [2];
    logic [11:0] reg_addr_v [2];
    logic [31:0] reg_wr_data_v [2];
    logic        reg_wr_en_v [2];
    logic        reg_rd_en_v [2];
    logic [31:0] reg_rd_data_v [2];

    logic [31:0] bank0 [8] = '{default: '0};
    logic [31:0] bank1 [8] = '{default: '0};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cnt [2] = '{0, 0};
    int rd_cnt [2] = '{0, 0};
    int rdy_cnt [2] = '{0, 0};
    int wr_cyc [2];
    int rd_cyc [2];
    logic [31:0] wr_dat [2];

    logic [31:0] model [2][8];
    int          wait_n [2] = '{0, 3};

    apb_reg_bridge #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_v[0]),
        .prdata(prdata_v[0]), .pslverr(pslverr_v[0]), .reg_addr(reg_addr_v[0]),
        .reg_wr_data(reg_wr_data_v[0]), .reg_wr_en(reg_wr_en_v[0]),
        .reg_rd_en(reg_rd_en_v[0]), .reg_rd_data(reg_rd_data_v[0])
    );

    apb_reg_bridge #(.WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_v[1]),
        .prdata(prdata_v[1]), .pslverr(pslverr_v[1]), .reg_addr(reg_addr_v[1]),
        .reg_wr_data(reg_wr_data_v[1]), .reg_wr_en(reg_wr_en_v[1]),
        .reg_rd_en(reg_rd_en_v[1]), .reg_rd_data(reg_rd_data_v[1])
    );

    always #5 clk = ~clk;

    assign reg_rd_data_v[0] = bank0[reg_addr_v[0][4:2]];
    assign reg_rd_data_v[1] = bank1[reg_addr_v[1][4:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reg_wr_en_v[0]) bank0[reg_addr_v[0][4:2]] <= reg_wr_data_v[0];
        if (reg_wr_en_v[1]) bank1[reg_addr_v[1][4:2]] <= reg_wr_data_v[1];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Strobe monitor, plus prdata/pslverr must be quiet whenever pready is low.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (reg_wr_en_v[i]) begin
                    wr_cnt[i]++;
                    wr_cyc[i] = cyc;
                    wr_dat[i] = reg_wr_data_v[i];
                end
                if (reg_rd_en_v[i]) begin
                    rd_cnt[i]++;
                    rd_cyc[i] = cyc;
                end
                if (pready_v[i]) rdy_cnt[i]++;
                else begin
                    check("prdata_idle", prdata_v[i], 32'h0);
                    check("pslverr_idle", 32'(pslverr_v[i]), 32'h0);
                end
            end
        end
    end

    // Reference model: the outcome of one transfer from the access rules alone.
    function automatic bit acc_err(input logic [11:0] a);
        return (a % 4 != 0) || (a > 12'h1C);
    endfunction

    function automatic int exp_lat(input int sel, input bit w, input logic [11:0] a,
                                   input logic [3:0] s);
        if (acc_err(a))                 return wait_n[sel] + 2;
        if (!w || s == 4'hF)            return wait_n[sel] + 3;
        if (s == 4'h0)                  return wait_n[sel] + 2;
        return wait_n[sel] + 4;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic model_apply(input int sel, input bit w, input logic [11:0] a,
                               input logic [31:0] d, input logic [3:0] s);
        if (w && !acc_err(a)) model[sel][a / 4] = merge(model[sel][a / 4], d, s);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        psel_v[0] = 1'b0; psel_v[1] = 1'b0; penable = 1'b0;
    endtask

    // One APB transfer; returns at the negedge where pready is seen, so a following call
    // presents its setup phase in the cycle right after RESP.
    task automatic xfer(input int sel, input bit w, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output bit err,
                        output logic [31:0] rdata, output int t0);
        int k = 0;
        @(posedge clk);
        #1;
        psel_v[sel] = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
        t0 = cyc;
        lat = -1; err = 1'b0; rdata = 'x;
        forever begin
            @(negedge clk);
            if (pready_v[sel]) begin
                lat = k; err = pslverr_v[sel]; rdata = prdata_v[sel];
                break;
            end
            if (k >= 40) begin
                errors++; checks++;
                $display("FAIL pready_timeout: no pready after %0d cycles", k);
                break;
            end
            @(posedge clk);
            #1;
            penable = 1'b1;
            k++;
        end
    endtask

    typedef struct {
        int          sel;
        bit          w;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lat;
        bit          err;
        logic [31:0] rdata;
        int          nwr;
        logic [31:0] wr_data;
        int          wr_off;
        int          nrd;
        int          rd_off;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int lat, t0, w0, r0, y0;
        bit err;
        logic [31:0] rd;
        vec_t v;

        vecs.push_back('{0, 1, 12'h000, 32'h0000_0103, 4'hF, 3, 0, 32'h0, 1, 32'h0000_0103, 2, 0, 0});
        vecs.push_back('{0, 1, 12'h00C, 32'h1234_5678, 4'hF, 3, 0, 32'h0, 1, 32'h1234_5678, 2, 0, 0});
        vecs.push_back('{0, 1, 12'h00C, 32'hAABB_CCDD, 4'h5, 4, 0, 32'h0, 1, 32'h12BB_56DD, 3, 1, 2});
        vecs.push_back('{0, 1, 12'h01C, 32'h0000_0002, 4'hF, 3, 0, 32'h0, 1, 32'h0000_0002, 2, 0, 0});
        vecs.push_back('{0, 0, 12'h01C, 32'hDEAD_BEEF, 4'h0, 3, 0, 32'h0000_0002, 0, 32'h0, 0, 1, 2});
        vecs.push_back('{0, 1, 12'h020, 32'h5555_5555, 4'hF, 2, 1, 32'h0, 0, 32'h0, 0, 0, 0});
        vecs.push_back('{0, 0, 12'h006, 32'h0, 4'h0, 2, 1, 32'h0, 0, 32'h0, 0, 0, 0});
        vecs.push_back('{0, 1, 12'h008, 32'h0000_FFFF, 4'h0, 2, 0, 32'h0, 0, 32'h0, 0, 0, 0});
        vecs.push_back('{0, 0, 12'h008, 32'h0, 4'hF, 3, 0, 32'h0, 0, 32'h0, 0, 1, 2});
        vecs.push_back('{1, 1, 12'h010, 32'hCAFE_0001, 4'hF, 6, 0, 32'h0, 1, 32'hCAFE_0001, 5, 0, 0});
        vecs.push_back('{1, 0, 12'h010, 32'h0, 4'h0, 6, 0, 32'hCAFE_0001, 0, 32'h0, 0, 1, 5});
        vecs.push_back('{1, 1, 12'h014, 32'h1122_3344, 4'h8, 7, 0, 32'h0, 1, 32'h1100_0000, 6, 1, 5});
        vecs.push_back('{1, 0, 12'h024, 32'h0, 4'h0, 5, 1, 32'h0, 0, 32'h0, 0, 0, 0});

        for (int i = 0; i < 2; i++) for (int j = 0; j < 8; j++) model[i][j] = '0;
        psel_v[0] = 1'b0; psel_v[1] = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", 32'(pready_v[0]), 32'h0);
        check("rst_reg_addr", 32'(reg_addr_v[0]), 32'h0);
        check("rst_wr_data", reg_wr_data_v[1], 32'h0);
        check("rst_strobes", 32'({reg_wr_en_v[0], reg_rd_en_v[0], reg_wr_en_v[1], reg_rd_en_v[1]}), 32'h0);
        rst = 1'b0;
        idle(2);

        // Documented cases, back-to-back within each instance.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (i > 0 && vecs[i-1].sel != v.sel) idle(1);
            w0 = wr_cnt[v.sel]; r0 = rd_cnt[v.sel];
            xfer(v.sel, v.w, v.addr, v.data, v.strb, lat, err, rd, t0);
            model_apply(v.sel, v.w, v.addr, v.data, v.strb);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(v.lat));
            check($sformatf("vec%0d_pslverr", i), 32'(err), 32'(v.err));
            check($sformatf("vec%0d_prdata", i), rd, v.rdata);
            check($sformatf("vec%0d_wr_count", i), 32'(wr_cnt[v.sel] - w0), 32'(v.nwr));
            check($sformatf("vec%0d_rd_count", i), 32'(rd_cnt[v.sel] - r0), 32'(v.nrd));
            if (v.nwr != 0) begin
                check($sformatf("vec%0d_wr_cycle", i), 32'(wr_cyc[v.sel] - t0), 32'(v.wr_off));
                check($sformatf("vec%0d_wr_data", i), wr_dat[v.sel], v.wr_data);
            end
            if (v.nrd != 0)
                check($sformatf("vec%0d_rd_cycle", i), 32'(rd_cyc[v.sel] - t0), 32'(v.rd_off));
        end
        idle(2);

        // penable already high while idle must not start a transfer.
        w0 = wr_cnt[0]; r0 = rd_cnt[0]; y0 = rdy_cnt[0];
        @(posedge clk);
        #1;
        psel_v[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h004; pstrb = 4'hF;
        idle(4);
        idle(3);
        check("penable_idle_activity", 32'(wr_cnt[0] - w0 + rd_cnt[0] - r0 + rdy_cnt[0] - y0), 32'h0);

        // Abort: psel dropped in WAIT on the 3-wait-state instance.
        w0 = wr_cnt[1]; y0 = rdy_cnt[1];
        @(posedge clk);
        #1;
        psel_v[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h7777_7777;
        pstrb = 4'hF;
        @(posedge clk);
        #1;
        penable = 1'b1;
        idle(1);
        idle(10);
        check("abort_wr_count", 32'(wr_cnt[1] - w0), 32'h0);
        check("abort_pready_count", 32'(rdy_cnt[1] - y0), 32'h0);
        check("abort_bank", bank1[1], model[1][1]);

        // Reset in the RMW_RD cycle of a partial write.
        w0 = wr_cnt[0]; y0 = rdy_cnt[0];
        @(posedge clk);
        #1;
        psel_v[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h018; pwdata = 32'h9999_9999;
        pstrb = 4'h3;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        check("rmw_rd_en", 32'(reg_rd_en_v[0]), 32'h1);
        rst = 1'b1;
        #1;
        check("rstmid_pready", 32'(pready_v[0]), 32'h0);
        check("rstmid_strobes", 32'({reg_wr_en_v[0], reg_rd_en_v[0]}), 32'h0);
        check("rstmid_reg_addr", 32'(reg_addr_v[0]), 32'h0);
        check("rstmid_wr_data", reg_wr_data_v[0], 32'h0);
        check("rstmid_prdata", prdata_v[0], 32'h0);
        psel_v[0] = 1'b0; penable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        check("rstmid_wr_count", 32'(wr_cnt[0] - w0), 32'h0);
        check("rstmid_pready_count", 32'(rdy_cnt[0] - y0), 32'h0);
        check("rstmid_bank", bank0[6], model[0][6]);

        // Random transfers against the model, mostly back-to-back.
        for (int sel = 0; sel < 2; sel++) begin
            for (int n = 0; n < 150; n++) begin
                bit          w = 1'($urandom_range(0, 1));
                logic [11:0] a = 12'($urandom_range(0, 11) * 4);
                logic [31:0] d = $urandom;
                logic [3:0]  s = 4'($urandom_range(0, 15));
                logic [31:0] er;
                int          ew, erd;
                if ($urandom_range(0, 5) == 0) a = 12'($urandom_range(0, 47));
                if ($urandom_range(0, 3) == 0) s = 4'hF;
                er  = (!w && !acc_err(a)) ? model[sel][a / 4] : 32'h0;
                ew  = (w && !acc_err(a) && s != 4'h0) ? 1 : 0;
                erd = (!acc_err(a) && (!w || (s != 4'hF && s != 4'h0))) ? 1 : 0;
                w0 = wr_cnt[sel]; r0 = rd_cnt[sel];
                xfer(sel, w, a, d, s, lat, err, rd, t0);
                check("rand_latency", 32'(lat), 32'(exp_lat(sel, w, a, s)));
                check("rand_pslverr", 32'(err), 32'(acc_err(a)));
                check("rand_prdata", rd, er);
                check("rand_wr_count", 32'(wr_cnt[sel] - w0), 32'(ew));
                check("rand_rd_count", 32'(rd_cnt[sel] - r0), 32'(erd));
                model_apply(sel, w, a, d, s);
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            end
            idle(2);
        end

        for (int j = 0; j < 8; j++) begin
            check("final_bank0", bank0[j], model[0][j]);
            check("final_bank1", bank1[j], model[1][j]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
